seven_seg_scan_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment scan controller; successor to the fixed 4-digit BCD display driver.
- Drives NUM_DIGITS common-anode digits: full hex decode, per-digit decimal point and enable, leading-zero blanking, per-digit blink, 16-level PWM brightness, anti-ghost blanking.
- Uses a tear-free shadow register.
- Sits between game/score logic and the board AN/CAT/DP pins; runs directly on the system clock with an internal prescaler, so no separate divided clock.

---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/seven_seg_hex_decoder.sv | 11 +
 rtl/seven_seg_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low hex glyphs
// in {g,f,e,d,c,b,a} order and the brightness resolution.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int   BRIGHT_LEVELS = 16;
  localparam seg_t SEG_OFF       = 7'h7F;

  // Entry n is the glyph for hex digit n (0 = 7'h40 ... F = 7'h0E).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness, blink,
// leading-zero blanking, anti-ghost blanking and a frame-aligned shadow register.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int PHASE_CYCLES = 781,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  input  logic                    update,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              CAT,
  output logic                    DP,
  output logic                    frame_start
);

  localparam int PHASE_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int DIGIT_W = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] BLANK_LIM   = PHASE_W'(BLANK_CYCLES);
  localparam logic [3:0]         BRIGHT_LAST = 4'(BRIGHT_LEVELS - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST  = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_blank;
    logic [3:0]              brightness;
  } disp_cfg_t;

  logic [PHASE_W-1:0] r_phase_cnt;
  logic [3:0]         r_bright_phase;
  logic [DIGIT_W-1:0] r_digit_idx;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_blink_phase;

  disp_cfg_t r_pending;
  disp_cfg_t r_shadow;
  logic      r_pending_valid;

  disp_cfg_t             w_in_cfg;
  logic                  w_phase_tc;
  logic                  w_bright_tc;
  logic                  w_digit_wrap;
  logic                  w_frame_wrap;
  logic [NUM_DIGITS-1:0] w_lz_hide;
  logic                  w_zero_run;
  logic [3:0]            w_nibble;
  seg_t                  w_seg;
  logic                  w_guard;
  logic                  w_visible;
  logic                  w_frame_first;
  logic [NUM_DIGITS-1:0] w_an_on;

  assign w_in_cfg = '{value: value, dp: dp_in, digit_en: digit_en,
                      blink_mask: blink_mask, lz_blank: lz_blank,
                      brightness: brightness};

  assign w_phase_tc   = (r_phase_cnt == PHASE_LAST);
  assign w_bright_tc  = w_phase_tc && (r_bright_phase == BRIGHT_LAST);
  assign w_digit_wrap = w_bright_tc && (r_digit_idx == DIGIT_LAST);
  assign w_frame_wrap = w_digit_wrap && (r_frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase_cnt    <= '0;
      r_bright_phase <= '0;
      r_digit_idx    <= '0;
      r_frame_cnt    <= '0;
      r_blink_phase  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every counter sees the same pre-edge terminal
      // counts, making the cascade advance as one coherent step.
      if (w_phase_tc) begin
        r_phase_cnt    <= '0;
        r_bright_phase <= r_bright_phase + 4'd1;
      end else begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end
      if (w_bright_tc)  r_digit_idx   <= w_digit_wrap ? '0 : r_digit_idx + 1'b1;
      if (w_digit_wrap) r_frame_cnt   <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
      if (w_frame_wrap) r_blink_phase <= ~r_blink_phase;
    end
  end

  // A write landing on the transfer edge stays pending; the older data moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: pending/shadow are cleared so nothing lights before the first
      // update reaches the display, rather than showing power-up garbage.
      r_pending       <= '0;
      r_shadow        <= '0;
      r_pending_valid <= 1'b0;
    end else begin
      if (update) begin
        r_pending       <= w_in_cfg;
        r_pending_valid <= 1'b1;
      end else if (w_digit_wrap) begin
        r_pending_valid <= 1'b0;
      end
      if (w_digit_wrap && r_pending_valid) r_shadow <= r_pending;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; no latches.
    w_zero_run = 1'b1;
    w_lz_hide  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_shadow.value[4*k +: 4] == 4'h0);
      if (k != 0) w_lz_hide[k] = r_shadow.lz_blank & w_zero_run;
    end
  end

  assign w_nibble = r_shadow.value[4*r_digit_idx +: 4];

  seven_seg_hex_decoder u_hex_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  assign w_guard   = (r_bright_phase == 4'd0) && (r_phase_cnt < BLANK_LIM);
  assign w_visible = r_shadow.digit_en[r_digit_idx]
                   & ~w_lz_hide[r_digit_idx]
                   & ~(r_shadow.blink_mask[r_digit_idx] & r_blink_phase)
                   & (r_bright_phase < r_shadow.brightness)
                   & ~w_guard;

  assign w_frame_first = (r_digit_idx == '0) && (r_bright_phase == 4'd0) &&
                         (r_phase_cnt == '0);
  assign w_an_on       = ~(NUM_DIGITS'(1) << r_digit_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN          <= '1;
      CAT         <= SEG_OFF;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      AN          <= w_visible ? w_an_on : '1;
      CAT         <= w_visible ? w_seg : SEG_OFF;
      DP          <= w_visible ? ~r_shadow.dp[r_digit_idx] : 1'b1;
      frame_start <= w_frame_first;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: per-slot expectations are queued at each frame start and
// compared against what the pins show as each slot completes.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int PC    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = 16 * PC;
  localparam int FRAME = SLOT * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, digit_en = '0, blink_mask = '0, brightness = '0;
  logic        lz_blank = 1'b0, update = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  CAT;
  logic        DP, frame_start;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .PHASE_CYCLES(PC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .brightness(brightness),
    .update(update), .AN(AN), .CAT(CAT), .DP(DP), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic [3:0]      blink;
    logic            lz;
    logic [3:0]      br;
    logic [3:0]      vis;   // shown when not blinking and brightness > 0
    logic [3:0][6:0] cat;
    int              n_frames;
  } vec_t;

  typedef struct {
    int         digit;
    int         low_cnt;
    logic [3:0] an;
    logic [6:0] cat;
    logic       dp;
    int         first;
    int         last;
  } slot_exp_t;

  slot_exp_t exp_q[$];
  vec_t      vecs[10];
  int        checks   = 0;
  int        failures = 0;
  int        fs_cnt;

  always @(posedge clk or negedge rst)
    if (!rst) fs_cnt <= 0;
    else if (frame_start) fs_cnt <= fs_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dp, en, bl,
                              input logic lz, input logic [3:0] br, vis,
                              input logic [6:0] c3, c2, c1, c0, input int nf);
    vec_t v;
    v.value = val; v.dp = dp; v.en = en; v.blink = bl; v.lz = lz; v.br = br;
    v.vis = vis; v.cat = {c3, c2, c1, c0}; v.n_frames = nf;
    return v;
  endfunction

  task automatic drive_cfg(input vec_t v);
    value = v.value; dp_in = v.dp; digit_en = v.en; blink_mask = v.blink;
    lz_blank = v.lz; brightness = v.br;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * FRAME);
    if (!frame_start) check("frame_start_timeout", 0, 1);
  endtask

  // Measures one whole frame; optional update pulses at frame cycles u1/u2.
  task automatic measure_frame(input vec_t v, input int u1, input logic [15:0] v1,
                               input int u2, input logic [15:0] v2);
    int fidx, blink_ph, low_cnt, first, last, incons, multi, offbad, fsbad;
    logic [3:0] an_s;
    logic [6:0] cat_s;
    logic       dp_s;
    slot_exp_t  e;
    wait_fs();
    fidx     = fs_cnt;
    blink_ph = (fidx / BF) % 2;
    for (int d = 0; d < ND; d++) begin
      logic vis;
      vis = v.vis[d] && !(v.blink[d] && blink_ph == 1) && (v.br != 0);
      e.digit = d;
      e.low_cnt = vis ? PC * int'(v.br) - BC : 0;
      e.an = ~(4'b0001 << d);
      e.cat = v.cat[d];
      e.dp = ~v.dp[d];
      e.first = BC;
      e.last = PC * int'(v.br) - 1;
      exp_q.push_back(e);
    end
    multi = 0; offbad = 0; fsbad = 0;
    low_cnt = 0; first = -1; last = -1; incons = 0;
    an_s = '1; cat_s = '1; dp_s = 1'b1;
    for (int j = 0; j < FRAME; j++) begin
      int o;
      if (j > 0) @(negedge clk);
      o = j % SLOT;
      if (o == 0) begin
        low_cnt = 0; first = -1; last = -1; incons = 0;
      end
      if ($countones(~AN) > 1) multi++;
      if (AN != 4'hF) begin
        if (first < 0) begin
          first = o; an_s = AN; cat_s = CAT; dp_s = DP;
        end else if ({AN, CAT, DP} != {an_s, cat_s, dp_s}) begin
          incons++;
        end
        low_cnt++;
        last = o;
      end else if (CAT != 7'h7F || DP != 1'b1) begin
        offbad++;
      end
      if (frame_start != (j == 0)) fsbad++;
      if (o == SLOT - 1) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("f%0d_d%0d_lit_cycles", fidx, e.digit), low_cnt, e.low_cnt);
          if (e.low_cnt > 0) begin
            check($sformatf("f%0d_d%0d_an_cat_dp_first_last", fidx, e.digit),
                  {4'h0, an_s, cat_s, dp_s, 8'(first), 8'(last)},
                  {4'h0, e.an, e.cat, e.dp, 8'(e.first), 8'(e.last)});
            check($sformatf("f%0d_d%0d_stable", fidx, e.digit), incons, 0);
          end
        end
      end
      if (j == u1) begin
        value = v1; update = 1'b1;
      end else if (j == u2) begin
        value = v2; update = 1'b1;
      end else begin
        update = 1'b0;
      end
    end
    check($sformatf("f%0d_one_anode", fidx), multi, 0);
    check($sformatf("f%0d_off_pins", fidx), offbad, 0);
    check($sformatf("f%0d_frame_start_pos", fidx), fsbad, 0);
  endtask

  initial begin
    int   lit;
    vec_t base;

    vecs[0] = mk(16'h12AF, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15, 4'hF, 7'h79, 7'h24, 7'h08, 7'h0E, 1);
    vecs[1] = mk(16'h0030, 4'h0, 4'hF, 4'h0, 1'b1, 4'd15, 4'h3, 7'h7F, 7'h7F, 7'h30, 7'h40, 1);
    vecs[2] = mk(16'h0000, 4'h0, 4'hF, 4'h0, 1'b1, 4'd15, 4'h1, 7'h7F, 7'h7F, 7'h7F, 7'h40, 1);
    vecs[3] = mk(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15, 4'hF, 7'h40, 7'h40, 7'h40, 7'h40, 1);
    vecs[4] = mk(16'h3456, 4'h5, 4'hF, 4'h0, 1'b0, 4'd4,  4'hF, 7'h30, 7'h19, 7'h12, 7'h02, 1);
    vecs[5] = mk(16'h89BC, 4'h0, 4'hA, 4'h0, 1'b0, 4'd8,  4'hA, 7'h00, 7'h10, 7'h03, 7'h46, 1);
    vecs[6] = mk(16'h1111, 4'h0, 4'hF, 4'h0, 1'b0, 4'd0,  4'hF, 7'h79, 7'h79, 7'h79, 7'h79, 3);
    vecs[7] = mk(16'hDE70, 4'h0, 4'hF, 4'h0, 1'b1, 4'd1,  4'hF, 7'h21, 7'h06, 7'h78, 7'h40, 1);
    vecs[8] = mk(16'h0500, 4'hF, 4'hF, 4'h0, 1'b1, 4'd15, 4'h7, 7'h7F, 7'h12, 7'h40, 7'h40, 1);
    vecs[9] = mk(16'h12AF, 4'h0, 4'hF, 4'h2, 1'b0, 4'd15, 4'hF, 7'h79, 7'h24, 7'h08, 7'h0E, 4);

    repeat (3) @(negedge clk);
    check("reset_an", AN, 4'hF);
    check("reset_cat", CAT, 7'h7F);
    check("reset_dp", DP, 1'b1);
    check("reset_frame_start", frame_start, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_cfg(vecs[i]);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      wait_fs();
      for (int f = 0; f < vecs[i].n_frames; f++)
        measure_frame(vecs[i], -1, 16'h0, -1, 16'h0);
    end

    // Mid-frame update, then back-to-back updates around the transfer edge.
    base = vecs[0];
    drive_cfg(base);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_fs();
    measure_frame(base, 2 * SLOT + 10, 16'h1111, -1, 16'h0);
    measure_frame(mk(16'h1111, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15, 4'hF,
                     7'h79, 7'h79, 7'h79, 7'h79, 1), 100, 16'h5555, FRAME - 2, 16'h7777);
    measure_frame(mk(16'h5555, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15, 4'hF,
                     7'h12, 7'h12, 7'h12, 7'h12, 1), -1, 16'h0, -1, 16'h0);
    measure_frame(mk(16'h7777, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15, 4'hF,
                     7'h78, 7'h78, 7'h78, 7'h78, 1), -1, 16'h0, -1, 16'h0);

    // Asynchronous reset in the middle of digit 2's lit window.
    wait_fs();
    repeat (2 * SLOT + 20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_an", AN, 4'hF);
    check("async_reset_cat", CAT, 7'h7F);
    check("async_reset_dp", DP, 1'b1);
    check("async_reset_frame_start", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    drive_cfg(vecs[0]);
    rst = 1'b1;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    check("restart_frame_start", frame_start, 1'b1);
    lit = (AN != 4'hF) ? 1 : 0;
    for (int j = 1; j < FRAME; j++) begin
      @(negedge clk);
      if (AN != 4'hF) lit++;
    end
    check("restart_first_frame_dark", lit, 0);
    measure_frame(vecs[0], -1, 16'h0, -1, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
